// File: rtl/fft_uart_pkg.sv
// Shared types for the UART-to-FFT frame assembly path: sample type, parser
// states and header length.
package fft_uart_pkg;
  typedef logic [15:0] sample_t;
  typedef enum logic [1:0] {S_HDR0, S_HDR1, S_MSB, S_LSB} asm_state_e;
  localparam int HDR_BYTES = 2;
endpackage

// File: rtl/uart_frame_assembler_sample_fifo.sv
// sample_fifo: first-word-fall-through synchronous FIFO with async reset.
// A push while full is accepted only when a pop happens in the same cycle.
module sample_fifo
  import fft_uart_pkg::*;
#(
  parameter int WIDTH = 23,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign head_data = mem_q[rd_ptr_q];
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= push_data;
    end
  end
endmodule

// File: rtl/uart_frame_assembler.sv
// uart_frame_assembler: parses header + N_SAMPLES 16-bit MSB-first samples from
// the UART byte stream into a sample FIFO. Macro SYNC_CHECK_EN enables header sync checking.
module uart_frame_assembler
  import fft_uart_pkg::*;
#(
  parameter int         N_SAMPLES      = 128,
  parameter int         FIFO_DEPTH     = 8,
  parameter int         TIMEOUT_CYCLES = 640,
  parameter logic [7:0] SYNC_BYTE      = 8'h00
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rx_dv,
  input  logic [7:0]                   rx_byte,
  output logic [15:0]                  smp_data,
  output logic [$clog2(N_SAMPLES)-1:0] smp_idx,
  output logic                         smp_last,
  output logic                         smp_valid,
  input  logic                         smp_ready,
  output logic [15:0]                  frame_hdr,
  output logic                         frame_done,
  output logic                         frame_err,
  output logic                         overflow,
  output logic                         busy,
  output logic [1:0]                   dbg_state
);
  localparam int IW = $clog2(N_SAMPLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW = IW + 16;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_SAMPLES - 1);
  localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES);
`ifdef SYNC_CHECK_EN
  localparam bit SYNC_EN = 1'b1;
`else
  localparam bit SYNC_EN = 1'b0;
`endif

  asm_state_e    state_q, state_d;
  logic [7:0]    hdr0_q, hdr0_d;
  logic [7:0]    msb_q, msb_d;
  logic [15:0]   frame_hdr_q, frame_hdr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          frame_done_q, frame_done_d;
  logic          frame_err_q, frame_err_d;
  logic          overflow_q, overflow_d;

  logic          push, pop, fifo_full, fifo_empty;
  sample_t       push_sample;
  logic [FW-1:0] fifo_head;

  // Output stream: smp_valid means the FIFO head is presented; the head is
  // consumed on any cycle with smp_valid && smp_ready, and holds otherwise.
  assign pop         = smp_valid && smp_ready;
  assign push_sample = {msb_q, rx_byte};

  always_comb begin
    state_d      = state_q;
    hdr0_d       = hdr0_q;
    msb_d        = msb_q;
    frame_hdr_d  = frame_hdr_q;
    idx_d        = idx_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    overflow_d   = overflow_q;
    push         = 1'b0;
    tmo_d        = (state_q == S_HDR0 || rx_dv) ? '0 : tmo_q + 1'b1;
    if (rx_dv) begin
      case (state_q)
        S_HDR0: begin
          if (SYNC_EN && rx_byte != SYNC_BYTE) begin
            frame_err_d = 1'b1;
          end else begin
            hdr0_d  = rx_byte;
            state_d = S_HDR1;
          end
        end
        S_HDR1: begin
          frame_hdr_d = {hdr0_q, rx_byte};
          idx_d       = '0;
          state_d     = S_MSB;
        end
        S_MSB: begin
          msb_d   = rx_byte;
          state_d = S_LSB;
        end
        S_LSB: begin
          push = 1'b1;
          if (fifo_full && !pop) overflow_d = 1'b1;
          // idx advances even when the sample is dropped, so frames stay aligned
          if (idx_q == LAST_IDX) begin
            idx_d        = '0;
            frame_done_d = 1'b1;
            state_d      = S_HDR0;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_MSB;
          end
        end
        default: state_d = S_HDR0;
      endcase
    end else if (state_q != S_HDR0 && tmo_q == TO_LIMIT) begin
      // A byte arriving in this same cycle takes the branch above instead
      frame_err_d = 1'b1;
      msb_d       = '0;
      tmo_d       = '0;
      state_d     = S_HDR0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_HDR0;
      hdr0_q       <= '0;
      msb_q        <= '0;
      frame_hdr_q  <= '0;
      idx_q        <= '0;
      tmo_q        <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hdr0_q       <= hdr0_d;
      msb_q        <= msb_d;
      frame_hdr_q  <= frame_hdr_d;
      idx_q        <= idx_d;
      tmo_q        <= tmo_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      overflow_q   <= overflow_d;
    end
  end

  sample_fifo #(
    .WIDTH(FW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data({idx_q, push_sample}),
    .pop      (pop),
    .head_data(fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign smp_valid  = !fifo_empty;
  assign smp_data   = fifo_head[15:0];
  assign smp_idx    = fifo_head[FW-1:16];
  assign smp_last   = (smp_idx == LAST_IDX);
  assign frame_hdr  = frame_hdr_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;
  assign busy       = (state_q != S_HDR0);
  assign dbg_state  = state_q;
endmodule
